// File: rtl/divmod_arbiter_pkg.sv
// Shared definitions for the divmod arbiter slice.
//   state_t     : arbiter FSM states (IDLE, CALC, DONE)
//   WIDTH_DEF   : default operand / quotient / remainder width
//   DIVISOR_DEF : default constant divisor
//   CNT_W       : width of the division step counter
package divmod_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          WIDTH_DEF   = 32;
    localparam int unsigned DIVISOR_DEF = 1234101;
    localparam int          CNT_W       = 6;

endpackage

// File: rtl/divmod_arbiter_if.sv
// Handshake bundle between two requesters / one consumer and the arbiter.
//   req0_*/req1_* : valid/ready request channels carrying a dividend
//   resp_*        : valid/ready response channel (owner id, quotient, remainder)
//   busy          : arbiter is not idle
// Modports: slave = arbiter side, master = requester/consumer side.
interface divmod_arbiter_if
    import divmod_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_dividend;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_dividend;
    logic             req1_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_quot;
    logic [WIDTH-1:0] resp_rem;
    logic             busy;

    modport slave (
        input  req0_valid, req0_dividend, req1_valid, req1_dividend, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_quot, resp_rem, busy
    );

    modport master (
        output req0_valid, req0_dividend, req1_valid, req1_dividend, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_quot, resp_rem, busy
    );
endinterface

// File: rtl/divmod_iter_core.sv
// Iterative restoring divider by a constant, one quotient bit per cycle, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load dividend, clear partial remainder and counter
//   dividend   : operand sampled on start
//   quot, rem  : result, valid while done is high and held until next start
//   done       : all WIDTH steps completed
module divmod_iter_core
    import divmod_arbiter_pkg::*;
#(
    parameter int          WIDTH   = WIDTH_DEF,
    parameter int unsigned DIVISOR = DIVISOR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done
);
    localparam logic [WIDTH:0] DIV_EXT = (WIDTH+1)'(DIVISOR);

    logic [WIDTH-1:0] q_sr;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   acc;      // partial remainder
    logic [CNT_W-1:0] cnt;
    logic             active;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // NOTE: every signal assigned in a combinational block gets a value on
    // every path, otherwise synthesis infers a latch.
    always_comb begin
        shifted = {acc[WIDTH-1:0], q_sr[WIDTH-1]};
        diff    = shifted - DIV_EXT;
        // acc[WIDTH] is always zero after a step (remainder < DIVISOR); folding
        // it in keeps the comparison correct for the full register width.
        fits    = acc[WIDTH] | (shifted >= DIV_EXT);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, because the result outputs
        // are required to read zero while in reset.
        if (!rst_n) begin
            q_sr   <= '0;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            q_sr   <= dividend;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= fits ? diff : shifted;
            q_sr   <= {q_sr[WIDTH-2:0], fits};
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
                active <= 1'b0;
            end
        end
    end

    assign quot = q_sr;
    assign rem  = acc[WIDTH-1:0];
    assign done = !active && (cnt == CNT_W'(WIDTH));

endmodule

// File: rtl/divmod_arbiter.sv
// Two-requester round-robin front end for a constant-divisor divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : divmod_arbiter_if.slave (request channels, response channel, busy)
// One request is served at a time: IDLE accepts, CALC runs the divider, DONE
// holds the result until the consumer takes it.
module divmod_arbiter
    import divmod_arbiter_pkg::*;
#(
    parameter int          WIDTH   = WIDTH_DEF,
    parameter int unsigned DIVISOR = DIVISOR_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    divmod_arbiter_if.slave bus
);
    state_t           state, state_nxt;
    logic             last_grant;
    logic             resp_id_q;
    logic             grant;
    logic             accept;
    logic             core_done;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] core_quot;
    logic [WIDTH-1:0] core_rem;

    always_comb begin
        // On a tie the requester not served last wins; otherwise whichever is valid.
        grant        = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        // rst_n gating keeps both readies low throughout reset.
        accept       = rst_n && (state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
        sel_dividend = grant ? bus.req1_dividend : bus.req0_dividend;

        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)         state_nxt = ST_CALC;
            ST_CALC: if (core_done)      state_nxt = ST_DONE;
            ST_DONE: if (bus.resp_ready) state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            resp_id_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant;
                resp_id_q  <= grant;
            end
        end
    end

    divmod_iter_core #(
        .WIDTH   (WIDTH),
        .DIVISOR (DIVISOR)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept),
        .dividend (sel_dividend),
        .quot     (core_quot),
        .rem      (core_rem),
        .done     (core_done)
    );

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept &&  grant;
    assign bus.resp_valid = (state == ST_DONE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_quot  = core_quot;
    assign bus.resp_rem   = core_rem;

endmodule

// File: tb/tb_divmod_arbiter.sv
// Directed bench for divmod_arbiter (WIDTH=32, DIVISOR=1234101).
module tb_divmod_arbiter;
    import divmod_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    divmod_arbiter_if #(.WIDTH(32)) bus ();

    divmod_arbiter #(
        .WIDTH   (32),
        .DIVISOR (1234101)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges counted from the current point until resp_valid is seen (capped).
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_req(input bit who, input logic [31:0] d, output int lat);
        int n;
        if (who) begin bus.req1_valid = 1'b1; bus.req1_dividend = d; end
        else     begin bus.req0_valid = 1'b1; bus.req0_dividend = d; end
        #1;
        n = 0;
        while (!(who ? bus.req1_ready : bus.req0_ready) && n < 100) begin
            tick();
            n++;
        end
        check("ready_seen", 32'(who ? bus.req1_ready : bus.req0_ready), 32'd1);
        tick();
        // Scramble the operand after acceptance; the result must not change.
        bus.req0_valid = 1'b0; bus.req0_dividend = 32'hDEAD_BEEF;
        bus.req1_valid = 1'b0; bus.req1_dividend = 32'hBEEF_DEAD;
        wait_resp(lat);
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("consumed", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  32'(bus.resp_valid), 32'd0);
        check({tag, "_busy"},   32'(bus.busy),       32'd0);
        check({tag, "_id"},     32'(bus.resp_id),    32'd0);
        check({tag, "_quot"},   bus.resp_quot,       32'd0);
        check({tag, "_rem"},    bus.resp_rem,        32'd0);
        check({tag, "_ready0"}, 32'(bus.req0_ready), 32'd0);
        check({tag, "_ready1"}, 32'(bus.req1_ready), 32'd0);
    endtask

    initial begin
        int   lat;
        int   seen;
        logic exp_id [4];
        logic [31:0] exp_q [2];
        logic [31:0] exp_r [2];

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_dividend = '0;
        bus.req1_valid = 1'b0; bus.req1_dividend = '0;
        bus.resp_ready = 1'b0;

        // ---- Reset values, with requester 0 already valid ----
        bus.req0_valid    = 1'b1;
        bus.req0_dividend = 32'hFFFF_FFFF;
        repeat (2) tick();
        check_reset_outputs("rst");

        // ---- Single request: accept on first edge after release ----
        rst_n = 1'b1;
        #1;
        check("single_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0; bus.req0_dividend = 32'h0;
        check("single_busy", 32'(bus.busy), 32'd1);
        wait_resp(lat);
        check("single_latency", 32'(lat), 32'd33);
        check("single_id",   32'(bus.resp_id), 32'd0);
        check("single_quot", bus.resp_quot, 32'd3480);
        check("single_rem",  bus.resp_rem,  32'd295815);
        consume();
        check("single_idle", 32'(bus.busy), 32'd0);

        // ---- Divisor boundaries ----
        do_req(1'b0, 32'd1234100, lat);
        check("bnd_a_latency", 32'(lat), 32'd33);
        check("bnd_a_quot", bus.resp_quot, 32'd0);
        check("bnd_a_rem",  bus.resp_rem,  32'd1234100);
        consume();
        do_req(1'b0, 32'd1234101, lat);
        check("bnd_b_quot", bus.resp_quot, 32'd1);
        check("bnd_b_rem",  bus.resp_rem,  32'd0);
        consume();
        do_req(1'b0, 32'd0, lat);
        check("bnd_c_quot", bus.resp_quot, 32'd0);
        check("bnd_c_rem",  bus.resp_rem,  32'd0);
        consume();

        // ---- Simultaneous requests: round robin 0,1,0,1 ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_q  = '{32'd81, 32'd0};         // 100000000 / 1234101, 7 / 1234101
        exp_r  = '{32'd37819, 32'd7};
        bus.req0_valid = 1'b1; bus.req0_dividend = 32'd100000000;
        bus.req1_valid = 1'b1; bus.req1_dividend = 32'd7;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_resp(lat);
            check($sformatf("rr%0d_valid", i), 32'(bus.resp_valid), 32'd1);
            check($sformatf("rr%0d_id", i), 32'(bus.resp_id), 32'(exp_id[i]));
            check($sformatf("rr%0d_quot", i), bus.resp_quot, exp_q[int'(exp_id[i])]);
            check($sformatf("rr%0d_rem", i),  bus.resp_rem,  exp_r[int'(exp_id[i])]);
            tick();
            check($sformatf("rr%0d_released", i), 32'(bus.resp_valid), 32'd0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b0;
        wait_resp(lat);
        consume();

        // ---- Backpressure: hold DONE for 10 cycles ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        do_req(1'b0, 32'd2468203, lat);
        bus.req1_valid    = 1'b1;
        bus.req1_dividend = 32'd6170508;   // 5*1234101 + 3
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d_valid", i), 32'(bus.resp_valid), 32'd1);
            check($sformatf("bp%0d_quot", i),  bus.resp_quot, 32'd2);
            check($sformatf("bp%0d_rem", i),   bus.resp_rem,  32'd1);
            check($sformatf("bp%0d_id", i),    32'(bus.resp_id), 32'd0);
            check($sformatf("bp%0d_ready1", i), 32'(bus.req1_ready), 32'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_no_accept_on_consume", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.resp_ready = 1'b0;
        check("bp_idle_valid",  32'(bus.resp_valid), 32'd0);
        check("bp_idle_busy",   32'(bus.busy),       32'd0);
        check("bp_idle_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0; bus.req1_dividend = 32'h0;
        check("bp_accept_busy", 32'(bus.busy), 32'd1);
        wait_resp(lat);
        check("bp_r1_latency", 32'(lat), 32'd33);
        check("bp_r1_id",   32'(bus.resp_id), 32'd1);
        check("bp_r1_quot", bus.resp_quot, 32'd5);
        check("bp_r1_rem",  bus.resp_rem,  32'd3);
        consume();

        // ---- Reset abort during CALC ----
        bus.req0_valid = 1'b1; bus.req0_dividend = 32'hFFFF_FFFF;
        tick();
        bus.req0_valid = 1'b0;
        repeat (15) tick();
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        bus.req1_valid = 1'b1; bus.req1_dividend = 32'd2468203;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        bus.req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.resp_valid || bus.busy) seen++;
        end
        check("abort_no_response", 32'(seen), 32'd0);
        do_req(1'b1, 32'd2468203, lat);
        check("abort_r1_latency", 32'(lat), 32'd33);
        check("abort_r1_id",   32'(bus.resp_id), 32'd1);
        check("abort_r1_quot", bus.resp_quot, 32'd2);
        check("abort_r1_rem",  bus.resp_rem,  32'd1);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/divmod_arbiter.md
DIVMOD_ARBITER -- requirements
Module: divmod_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width.
REQ-002 SHALL have parameter DIVISOR, default 1234101, giving the constant divisor; it is nonzero and less than 2^WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port req0_valid, input, 1 bit: requester 0 presents a dividend.
REQ-006 SHALL have port req0_dividend, input, WIDTH bits: requester 0 operand.
REQ-007 SHALL have port req0_ready, output, 1 bit: requester 0 operand accepted this cycle when high together with req0_valid.
REQ-008 SHALL have ports req1_valid, req1_dividend and req1_ready, with widths and meanings identical to requester 0.
REQ-009 SHALL have port resp_valid, output, 1 bit: the result is available.
REQ-010 SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port resp_id, output, 1 bit: the index of the requester that owns the result.
REQ-012 SHALL have ports resp_quot and resp_rem, outputs, WIDTH bits each: the quotient (dividend / DIVISOR) and the remainder (dividend mod DIVISOR).
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement a 3-state FSM with states IDLE, CALC and DONE.
REQ-015 SHALL hold a 1-bit round-robin pointer, last_grant, that records the most recently served requester.
REQ-016 In IDLE, the arbiter SHALL grant the only valid requester; when both are valid, it SHALL grant the requester with index != last_grant.
REQ-017 reqN_ready SHALL be combinational, high only in IDLE and only for the granted requester; at most one ready is high per cycle.
REQ-018 On an accept edge (valid & ready), the block SHALL do the following:
- latch the dividend and requester id;
- update last_grant;
- clear the 6-bit iteration counter;
- move to CALC.
REQ-019 CALC SHALL perform one restoring-division step per cycle, MSB first, for exactly WIDTH cycles.
- The partial remainder register is WIDTH+1 bits wide, so no overflow occurs for any DIVISOR < 2^WIDTH.
REQ-020 After the WIDTH-th CALC edge, the FSM SHALL enter DONE; resp_valid SHALL be high from that point, i.e. WIDTH+1 edges after the accept edge.
REQ-021 In DONE, resp_quot, resp_rem and resp_id SHALL be held stable until the edge where resp_ready is high; that edge returns the FSM to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle as response consumption; earliest next accept is the cycle after the return to IDLE.
REQ-023 resp_rem SHALL always be < DIVISOR, and resp_quot*DIVISOR + resp_rem SHALL equal the latched dividend.
REQ-024 reqN_valid SHALL be ignored outside IDLE; the arbiter has no queueing and requesters hold valid until their ready is seen.
REQ-025 Dividend changes after acceptance SHALL NOT affect the result.

Reset
REQ-026 While rst_n is low, the block SHALL asynchronously set the following:
- state = IDLE;
- last_grant = 1, so requester 0 wins the first tie;
- counter = 0;
- all datapath registers = 0.
REQ-027 During reset, the outputs SHALL be resp_valid=0, resp_id=0, resp_quot=0, resp_rem=0, busy=0, req0_ready=0 and req1_ready=0.
REQ-028 A reset asserted during CALC or DONE SHALL abort the operation; no response is produced for the aborted request.
REQ-029 The first accept after reset SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, WIDTH_DEF=32 and DIVISOR_DEF=1234101.
REQ-031 The datapath SHALL be a sub-module, divmod_iter_core, containing the following:
- dividend/quotient shift register;
- partial remainder;
- counter;
- start/done pins.
REQ-032 The arbitration, the FSM and the response hold logic SHALL reside in divmod_arbiter.

Verification
REQ-033 Single request test: after reset, req0 presents 0xFFFFFFFF -> accept on the first edge; resp_valid rises 33 edges later with resp_id=0, quot=3480 and rem=295815.
REQ-034 Divisor boundary test: dividends 1234100, 1234101 and 0, each sent in turn -> (quot 0, rem 1234100), (quot 1, rem 0) and (quot 0, rem 0).
REQ-035 Simultaneous request test, with both requesters valid continuously right after reset -> service order is 0, 1, 0, 1.
- No requester is served twice in a row.
- Each result matches dividend/1234101.
REQ-036 Backpressure test: resp_ready is held low for 10 cycles in DONE -> resp_valid and the outputs stay stable; the accept of req1 occurs one cycle after resp_ready goes high.
REQ-037 Reset-abort test: rst_n is pulsed low at CALC cycle 15 -> outputs immediately return to reset values and no response appears.
- A subsequent req1 with dividend 2468203 returns quot 2 and rem 1.
